// File: rtl/pipeline_flow_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_pkg
// Purpose : Shared constants, types and helpers for the pipeline flow
//           controller (PC / IF-ID ownership and stage valid tracking).
// Contents: XLEN, PC_INC, NOP_INSTR_DEF, stage_valid_t, align_target()
// Revision: 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int              XLEN          = 32;
  localparam logic [XLEN-1:0] PC_INC        = 32'd4;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  // Valid bits of the back-end stages owned by the flow controller.
  typedef struct packed {
    logic id_ex;
    logic ex_mem;
  } stage_valid_t;

  // Branch targets are forced word aligned before being loaded into the PC.
  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] i_target);
    return {i_target[XLEN-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_flow_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_flow_ctrl_if
// Purpose : Bundles the hazard-unit controls, instruction memory handshake
//           and pipeline state outputs of the flow controller.
// Modports:
//   master - hazard unit / datapath side: drives stall, ifflush, idflush,
//            exflush, branch_taken, branch_target, imem_rdata; observes the
//            PC, IF/ID contents, stage valids and perf counters.
//   slave  - flow controller side (mirror of master).
// Revision: 1.0 - initial release
// ============================================================================
interface pipeline_flow_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipe_pkg::*;

  logic            stall;
  logic            ifflush;
  logic            idflush;
  logic            exflush;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] if_id_pc4;
  logic [XLEN-1:0] if_id_instr;
  logic            if_id_valid;
  logic            id_ex_valid;
  logic            ex_mem_valid;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output stall, ifflush, idflush, exflush, branch_taken, branch_target, imem_rdata,
    input  imem_addr, if_id_pc4, if_id_instr, if_id_valid, id_ex_valid, ex_mem_valid,
           stall_count, flush_count
  );

  modport slave (
    input  stall, ifflush, idflush, exflush, branch_taken, branch_target, imem_rdata,
    output imem_addr, if_id_pc4, if_id_instr, if_id_valid, id_ex_valid, ex_mem_valid,
           stall_count, flush_count
  );

endinterface
`default_nettype wire

// File: rtl/pipeline_flow_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Purpose : W-bit up counter that sticks at its all-ones value.
// Ports   :
//   clk      in  1  clock
//   rst      in  1  synchronous active-high clear
//   i_inc    in  1  count this cycle
//   o_count  out W  current count
// Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_inc,
  output logic [W-1:0]      o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_flow_ctrl
// Purpose : Applies hazard-unit stall / flush / branch redirect to the PC,
//           the IF/ID register and the ID/EX, EX/MEM valid bits of a
//           5-stage MIPS pipeline; counts stall cycles and accepted IF
//           flushes.
// Ports   :
//   clk  in  1  clock, all state on rising edge
//   rst  in  1  synchronous active-high reset, overrides everything
//   bus  pipeline_flow_ctrl_if.slave
//        in : stall, ifflush, idflush, exflush, branch_taken,
//             branch_target[31:0], imem_rdata[31:0]
//        out: imem_addr[31:0], if_id_pc4[31:0], if_id_instr[31:0],
//             if_id_valid, id_ex_valid, ex_mem_valid,
//             stall_count[CNT_W-1:0], flush_count[CNT_W-1:0]
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_flow_ctrl
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter int              CNT_W     = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pipeline_flow_ctrl_if.slave bus
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_if_id_instr;
  logic [XLEN-1:0] r_if_id_pc4;
  logic            r_if_id_valid;
  stage_valid_t    r_valid;

  logic [XLEN-1:0] w_pc_plus4;
  logic            w_flush_accept;
  logic [CNT_W-1:0] w_stall_count;
  logic [CNT_W-1:0] w_flush_count;

  // Natural 32-bit wrap takes 0xFFFF_FFFC to 0.
  assign w_pc_plus4 = r_pc + PC_INC;

  // A stalled cycle carries a stale ID branch decision, so the flush only
  // counts (and only applies) when the front end actually advances.
  assign w_flush_accept = bus.ifflush & ~bus.stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_pc4   <= '0;
      r_if_id_valid <= 1'b0;
      r_valid       <= '0;
    end else begin
      if (!bus.stall) begin
        r_pc        <= bus.branch_taken ? align_target(bus.branch_target) : w_pc_plus4;
        r_if_id_pc4 <= w_pc_plus4;
        if (bus.ifflush) begin
          r_if_id_instr <= NOP_INSTR;
          r_if_id_valid <= 1'b0;
        end else begin
          r_if_id_instr <= bus.imem_rdata;
          r_if_id_valid <= 1'b1;
        end
      end
      // Stall alone is enough to bubble ID/EX; EX/MEM is never held so the
      // load ahead of the stall drains.
      r_valid.id_ex  <= r_if_id_valid & ~(bus.stall | bus.idflush);
      r_valid.ex_mem <= r_valid.id_ex & ~bus.exflush;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (bus.stall),
    .o_count (w_stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_flush_accept),
    .o_count (w_flush_count)
  );

  assign bus.imem_addr    = r_pc;
  assign bus.if_id_pc4    = r_if_id_pc4;
  assign bus.if_id_instr  = r_if_id_instr;
  assign bus.if_id_valid  = r_if_id_valid;
  assign bus.id_ex_valid  = r_valid.id_ex;
  assign bus.ex_mem_valid = r_valid.ex_mem;
  assign bus.stall_count  = w_stall_count;
  assign bus.flush_count  = w_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_flow_ctrl
// Purpose : Self-checking bench for pipeline_flow_ctrl: directed scenarios
//           plus randomized hazard-control traffic, compared every cycle
//           against a behavioural model of the pipeline front end.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipeline_flow_ctrl;
  import pipe_pkg::*;

  localparam int          CNT_W    = 16;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_flow_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_flow_ctrl #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP),
    .CNT_W     (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory: word at address 0 is 0x8C01_0004, others vary by address.
  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return 32'h8C01_0004 ^ {a[27:0], 4'h0};
  endfunction
  assign bus.imem_rdata = imem_f(bus.imem_addr);

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_ifv, m_idv, m_exv;
  int          m_sc, m_fc;

  int checks   = 0;
  int failures = 0;

  task automatic set_in(input logic s, input logic ifl, input logic idf,
                        input logic exf, input logic bt, input logic [31:0] tgt);
    bus.stall         = s;
    bus.ifflush       = ifl;
    bus.idflush       = idf;
    bus.exflush       = exf;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, "_pc"},     bus.imem_addr, m_pc);
    chk({pfx, "_instr"},  bus.if_id_instr, m_instr);
    chk({pfx, "_pc4"},    bus.if_id_pc4, m_pc4);
    chk({pfx, "_ifv"},    {31'b0, bus.if_id_valid}, {31'b0, m_ifv});
    chk({pfx, "_idv"},    {31'b0, bus.id_ex_valid}, {31'b0, m_idv});
    chk({pfx, "_exv"},    {31'b0, bus.ex_mem_valid}, {31'b0, m_exv});
    chk({pfx, "_scnt"},   {16'b0, bus.stall_count}, 32'(m_sc));
    chk({pfx, "_fcnt"},   {16'b0, bus.flush_count}, 32'(m_fc));
  endtask

  // Next-cycle model derived from the pipeline rules: stage valids shift
  // forward first (using this cycle's contents), then the front end moves.
  task automatic model_step();
    logic [31:0] fetched;
    if (rst) begin
      m_pc = RESET_PC; m_instr = NOP; m_pc4 = 32'd0;
      m_ifv = 1'b0; m_idv = 1'b0; m_exv = 1'b0;
      m_sc = 0; m_fc = 0;
    end else begin
      m_exv = bus.exflush ? 1'b0 : m_idv;
      m_idv = (bus.stall || bus.idflush) ? 1'b0 : m_ifv;
      if (bus.stall) begin
        m_sc = (m_sc == CNT_MAX) ? CNT_MAX : m_sc + 1;
      end else begin
        fetched = imem_f(m_pc);
        m_pc4   = m_pc + 32'd4;
        if (bus.ifflush) begin
          m_instr = NOP; m_ifv = 1'b0;
          m_fc = (m_fc == CNT_MAX) ? CNT_MAX : m_fc + 1;
        end else begin
          m_instr = fetched; m_ifv = 1'b1;
        end
        m_pc = bus.branch_taken ? (bus.branch_target & 32'hFFFF_FFFC) : m_pc + 32'd4;
      end
    end
  endtask

  task automatic step(input bit do_chk, input string pfx);
    model_step();
    @(posedge clk);
    #1;
    if (do_chk) check_all(pfx);
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 32'h0);
    model_step();
    @(posedge clk); #1;
    step(1, "reset");
    chk("reset_pc_const", bus.imem_addr, RESET_PC);
    chk("reset_ifv_const", {31'b0, bus.if_id_valid}, 32'd0);
    rst = 1'b0;

    // 1: free run
    step(1, "t1a");
    chk("t1_pc4_const", bus.if_id_pc4, 32'd4);
    chk("t1_instr_const", bus.if_id_instr, 32'h8C01_0004);
    chk("t1_ifv_const", {31'b0, bus.if_id_valid}, 32'd1);
    step(1, "t1b");
    chk("t1_pc8_const", bus.imem_addr, 32'd8);

    // 2: two-cycle stall at PC=8
    set_in(1, 0, 0, 0, 0, 32'h0);
    step(1, "t2a");
    chk("t2a_idv_const", {31'b0, bus.id_ex_valid}, 32'd0);
    step(1, "t2b");
    chk("t2b_pc_const", bus.imem_addr, 32'd8);
    chk("t2b_scnt_const", {16'b0, bus.stall_count}, 32'd2);
    set_in(0, 0, 0, 0, 0, 32'h0);
    step(1, "t2c");
    step(1, "t2d");
    chk("t2d_pc_const", bus.imem_addr, 32'h10);

    // 3: taken branch with IF flush
    set_in(0, 1, 0, 0, 1, 32'h40);
    step(1, "t3");
    chk("t3_pc_const", bus.imem_addr, 32'h40);
    chk("t3_fcnt_const", {16'b0, bus.flush_count}, 32'd1);

    // 4: branch under stall is ignored, then re-resolves
    set_in(1, 1, 0, 0, 1, 32'h80);
    step(1, "t4a");
    chk("t4a_pc_const", bus.imem_addr, 32'h40);
    chk("t4a_fcnt_const", {16'b0, bus.flush_count}, 32'd1);
    set_in(0, 1, 0, 0, 1, 32'h80);
    step(1, "t4b");
    chk("t4b_pc_const", bus.imem_addr, 32'h80);

    // 5: PC wrap and unaligned target
    set_in(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step(1, "t5a");
    set_in(0, 0, 0, 0, 0, 32'h0);
    step(1, "t5b");
    chk("t5_wrap_const", bus.imem_addr, 32'h0);
    set_in(0, 0, 0, 0, 1, 32'h43);
    step(1, "t5c");
    chk("t5_align_const", bus.imem_addr, 32'h40);

    // Randomized traffic, including idflush/exflush and sporadic resets
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 3) == 0, $urandom);
      step(1, "rnd");
    end
    rst = 1'b0;

    // 6: saturate the stall counter, then reset mid-stall
    set_in(1, 1, 0, 0, 1, 32'h100);
    for (int i = 0; i < (1 << CNT_W) + 5; i++) step(0, "");
    check_all("t6_sat");
    chk("t6_scnt_const", {16'b0, bus.stall_count}, 32'h0000_FFFF);
    rst = 1'b1;
    step(1, "t6_rst");
    chk("t6_pc_const", bus.imem_addr, RESET_PC);
    chk("t6_exv_const", {31'b0, bus.ex_mem_valid}, 32'd0);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 32'h0);
    step(1, "t6_post");
    chk("t6_post_instr_const", bus.if_id_instr, imem_f(RESET_PC));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
